// File: rtl/versatile_fifo_pkg.sv
// Shared constants and pointer arithmetic for the versatile FIFO read side.
package versatile_fifo_pkg;

   localparam int unsigned DEF_ADR_WIDTH  = 11;
   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_PTR_WIDTH  = DEF_ADR_WIDTH + 1;

   // Modular distance a - b for pointers that are pw bits wide (pw < 32).
   function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned pw);
      logic [31:0] mask;
      mask = (32'd1 << pw) - 32'd1;
      return (a - b) & mask;
   endfunction

endpackage

// File: rtl/versatile_fifo_dptam_reader_if.sv
// Valid/ready byte stream from the FIFO reader to the SD data path consumer.
interface versatile_fifo_dptam_reader_if
   import versatile_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/versatile_fifo_skid2.sv
// Two-entry buffer that absorbs the RAM read latency; flush has priority.
module versatile_fifo_skid2
   import versatile_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [1:0]            count
);

   logic [DATA_WIDTH-1:0] mem_q [2];
   logic [DATA_WIDTH-1:0] mem_d [2];
   logic                  wr_idx_q, wr_idx_d;
   logic                  rd_idx_q, rd_idx_d;
   logic [1:0]            cnt_q, cnt_d;

   always_comb begin
      mem_d    = mem_q;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_idx_d = 1'b0;
         rd_idx_d = 1'b0;
         cnt_d    = 2'd0;
      end else begin
         if (push) begin
            mem_d[wr_idx_q] = push_data;
            wr_idx_d        = wr_idx_q + 1'b1;
         end
         if (pop) begin
            rd_idx_d = rd_idx_q + 1'b1;
         end
         cnt_d = 2'(cnt_q + 2'(push) - 2'(pop));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_idx_q <= 1'b0;
         rd_idx_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head_data = mem_q[rd_idx_q];
   assign count     = cnt_q;

endmodule

// File: rtl/versatile_fifo_dptam_reader.sv
// FIFO read-side controller: drives RAM port B and streams bytes to the consumer.
// Fetch/credit/pointer logic lives here; the 2-entry buffer is a sub-module.
module versatile_fifo_dptam_reader
   import versatile_fifo_pkg::*;
#(
   parameter int unsigned ADR_WIDTH  = DEF_ADR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADR_WIDTH:0]           wr_ptr,
   output logic [ADR_WIDTH:0]           rd_ptr,
   output logic [ADR_WIDTH:0]           level,
   input  logic                         flush,
   output logic [ADR_WIDTH-1:0]         ram_adr,
   output logic                         ram_we,
   output logic [DATA_WIDTH-1:0]        ram_d,
   input  logic [DATA_WIDTH-1:0]        ram_q,
   versatile_fifo_dptam_reader_if.master m_if,
   output logic                         err
);

   localparam int unsigned PTR_WIDTH = ADR_WIDTH + 1;
   localparam logic [31:0] DEPTH     = 32'd1 << ADR_WIDTH;

   logic [PTR_WIDTH-1:0]  fet_ptr_q, fet_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic                  pend_q, pend_d;
   logic                  err_q, err_d;
   logic [1:0]            buf_cnt;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  pop_c, push_c, fetch_c;
   logic [2:0]            credit_c;
   logic [31:0]           diff_c;

   assign pop_c  = m_if.m_valid & m_if.m_ready;
   assign push_c = pend_q & ~flush;

   // A fetch is issued only when the buffer can still hold the byte after the in-flight one lands.
   always_comb begin
      diff_c    = ptr_diff(32'(wr_ptr), 32'(rd_ptr_q), PTR_WIDTH);
      credit_c  = 3'(buf_cnt) + 3'(pend_q) - 3'(pop_c);
      fetch_c   = (fet_ptr_q != wr_ptr) && (credit_c < 3'd2);
      fet_ptr_d = fet_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      pend_d    = 1'b0;
      err_d     = err_q;
      if (flush) begin
         fet_ptr_d = wr_ptr;
         rd_ptr_d  = wr_ptr;
         err_d     = 1'b0;
      end else begin
         if (fetch_c) begin
            fet_ptr_d = fet_ptr_q + PTR_WIDTH'(1);
         end
         pend_d = fetch_c;
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
         end
         if (diff_c > DEPTH) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fet_ptr_q <= '0;
         rd_ptr_q  <= '0;
         pend_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         fet_ptr_q <= fet_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         pend_q    <= pend_d;
         err_q     <= err_d;
      end
   end

   versatile_fifo_skid2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid2 (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push_c),
      .push_data (ram_q),
      .pop       (pop_c),
      .head_data (head_data),
      .count     (buf_cnt)
   );

   assign rd_ptr       = rd_ptr_q;
   assign level        = PTR_WIDTH'(diff_c);
   assign ram_adr      = fet_ptr_q[ADR_WIDTH-1:0];
   assign ram_we       = 1'b0;
   assign ram_d        = '0;
   assign err          = err_q;
   assign m_if.m_valid = (buf_cnt != 2'd0);
   assign m_if.m_data  = head_data;

endmodule

// File: tb/tb_versatile_fifo_dptam_reader.sv
// Directed bench for the FIFO reader with a behavioural 1-cycle-latency RAM model.
module tb_versatile_fifo_dptam_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] wr_ptr = '0;
   logic [11:0] rd_ptr;
   logic [11:0] level;
   logic        flush = 1'b0;
   logic [10:0] ram_adr;
   logic        ram_we;
   logic [7:0]  ram_d;
   logic [7:0]  ram_q;
   logic        err;
   logic [7:0]  mem [0:2047];

   int n_cmp = 0;
   int n_mis = 0;

   versatile_fifo_dptam_reader_if #(.DATA_WIDTH(8)) s_if ();

   versatile_fifo_dptam_reader #(
      .ADR_WIDTH  (11),
      .DATA_WIDTH (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_ptr  (wr_ptr),
      .rd_ptr  (rd_ptr),
      .level   (level),
      .flush   (flush),
      .ram_adr (ram_adr),
      .ram_we  (ram_we),
      .ram_d   (ram_d),
      .ram_q   (ram_q),
      .m_if    (s_if.master),
      .err     (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ram_q <= mem[ram_adr];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      flush = 1'b0;
      wr_ptr = '0;
      s_if.m_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (s_if.m_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid got=%b exp=0", s_if.m_valid); end
      n_cmp++; if (s_if.m_data !== 8'h00) begin n_mis++; $display("FAIL reset_data got=%h exp=00", s_if.m_data); end
      n_cmp++; if (rd_ptr !== 12'h000) begin n_mis++; $display("FAIL reset_rd_ptr got=%h exp=000", rd_ptr); end
      n_cmp++; if (level !== 12'h000) begin n_mis++; $display("FAIL reset_level got=%h exp=000", level); end
      n_cmp++; if (ram_adr !== 11'h000) begin n_mis++; $display("FAIL reset_ram_adr got=%h exp=000", ram_adr); end
      n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL reset_err got=%b exp=0", err); end
      n_cmp++; if (ram_we !== 1'b0) begin n_mis++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
      n_cmp++; if (ram_d !== 8'h00) begin n_mis++; $display("FAIL reset_ram_d got=%h exp=00", ram_d); end
   endtask

   task automatic test_stream();
      logic        exp_v;
      logic [11:0] exp_rd;
      for (int i = 0; i < 4; i++) mem[i] = 8'(8'hA0 + i);
      s_if.m_ready = 1'b1;
      wr_ptr = 12'd4;
      for (int k = 1; k <= 7; k++) begin
         step();
         exp_v  = (k >= 2) && (k <= 5);
         exp_rd = (k <= 2) ? 12'd0 : ((k >= 6) ? 12'd4 : 12'(k - 2));
         n_cmp++; if (s_if.m_valid !== exp_v) begin n_mis++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", k, s_if.m_valid, exp_v); end
         if (exp_v) begin
            n_cmp++; if (s_if.m_data !== 8'(8'hA0 + k - 2)) begin n_mis++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", k, s_if.m_data, 8'(8'hA0 + k - 2)); end
         end
         n_cmp++; if (rd_ptr !== exp_rd) begin n_mis++; $display("FAIL stream_rd_ptr cyc=%0d got=%h exp=%h", k, rd_ptr, exp_rd); end
      end
      n_cmp++; if (level !== 12'd0) begin n_mis++; $display("FAIL stream_level got=%h exp=000", level); end
   endtask

   task automatic test_stall();
      logic        exp_v;
      logic [7:0]  exp_d;
      logic [10:0] exp_a;
      do_reset();
      for (int i = 0; i < 4; i++) mem[i] = 8'(8'hA0 + i);
      wr_ptr = 12'd4;
      for (int k = 1; k <= 14; k++) begin
         step();
         exp_v = (k >= 2) && (k <= 13);
         exp_d = (k <= 10) ? 8'hA0 : 8'(8'hA0 + k - 10);
         exp_a = (k <= 10) ? ((k < 2) ? 11'(k) : 11'd2) : ((k == 11) ? 11'd3 : 11'd4);
         n_cmp++; if (ram_adr !== exp_a) begin n_mis++; $display("FAIL stall_ram_adr cyc=%0d got=%h exp=%h", k, ram_adr, exp_a); end
         n_cmp++; if (s_if.m_valid !== exp_v) begin n_mis++; $display("FAIL stall_valid cyc=%0d got=%b exp=%b", k, s_if.m_valid, exp_v); end
         if (exp_v) begin
            n_cmp++; if (s_if.m_data !== exp_d) begin n_mis++; $display("FAIL stall_data cyc=%0d got=%h exp=%h", k, s_if.m_data, exp_d); end
         end
         if (k == 10) s_if.m_ready = 1'b1;
      end
      n_cmp++; if (rd_ptr !== 12'd4) begin n_mis++; $display("FAIL stall_rd_ptr got=%h exp=004", rd_ptr); end
   endtask

   task automatic test_wrap();
      logic        exp_v;
      logic [10:0] exp_a;
      mem[11'h7FE] = 8'hB0;
      mem[11'h7FF] = 8'hB1;
      mem[11'h000] = 8'hB2;
      mem[11'h001] = 8'hB3;
      wr_ptr = 12'h7FE;
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_cmp++; if (rd_ptr !== 12'h7FE) begin n_mis++; $display("FAIL wrap_start_rd_ptr got=%h exp=7fe", rd_ptr); end
      n_cmp++; if (ram_adr !== 11'h7FE) begin n_mis++; $display("FAIL wrap_start_ram_adr got=%h exp=7fe", ram_adr); end
      wr_ptr = 12'h802;
      for (int k = 1; k <= 7; k++) begin
         step();
         exp_v = (k >= 2) && (k <= 5);
         exp_a = 11'(11'h7FE + ((k < 4) ? k : 4));
         n_cmp++; if (ram_adr !== exp_a) begin n_mis++; $display("FAIL wrap_ram_adr cyc=%0d got=%h exp=%h", k, ram_adr, exp_a); end
         n_cmp++; if (s_if.m_valid !== exp_v) begin n_mis++; $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", k, s_if.m_valid, exp_v); end
         if (exp_v) begin
            n_cmp++; if (s_if.m_data !== 8'(8'hB0 + k - 2)) begin n_mis++; $display("FAIL wrap_data cyc=%0d got=%h exp=%h", k, s_if.m_data, 8'(8'hB0 + k - 2)); end
         end
      end
      n_cmp++; if (rd_ptr !== 12'h802) begin n_mis++; $display("FAIL wrap_rd_ptr got=%h exp=802", rd_ptr); end
   endtask

   task automatic test_flush();
      do_reset();
      wr_ptr = 12'd10;
      step();
      step();
      step();
      n_cmp++; if (s_if.m_valid !== 1'b1) begin n_mis++; $display("FAIL flush_pre_valid got=%b exp=1", s_if.m_valid); end
      n_cmp++; if (level !== 12'd10) begin n_mis++; $display("FAIL flush_pre_level got=%h exp=00a", level); end
      n_cmp++; if (ram_adr !== 11'd2) begin n_mis++; $display("FAIL flush_pre_ram_adr got=%h exp=002", ram_adr); end
      flush = 1'b1;
      s_if.m_ready = 1'b1;
      step();
      flush = 1'b0;
      n_cmp++; if (s_if.m_valid !== 1'b0) begin n_mis++; $display("FAIL flush_valid got=%b exp=0", s_if.m_valid); end
      n_cmp++; if (rd_ptr !== 12'd10) begin n_mis++; $display("FAIL flush_rd_ptr got=%h exp=00a", rd_ptr); end
      n_cmp++; if (level !== 12'd0) begin n_mis++; $display("FAIL flush_level got=%h exp=000", level); end
      n_cmp++; if (ram_adr !== 11'd10) begin n_mis++; $display("FAIL flush_ram_adr got=%h exp=00a", ram_adr); end
      mem[10] = 8'hC5;
      wr_ptr = 12'd11;
      step();
      n_cmp++; if (s_if.m_valid !== 1'b0) begin n_mis++; $display("FAIL post_flush_early_valid got=%b exp=0", s_if.m_valid); end
      step();
      n_cmp++; if (s_if.m_valid !== 1'b1) begin n_mis++; $display("FAIL post_flush_valid got=%b exp=1", s_if.m_valid); end
      n_cmp++; if (s_if.m_data !== 8'hC5) begin n_mis++; $display("FAIL post_flush_data got=%h exp=c5", s_if.m_data); end
      step();
      n_cmp++; if (s_if.m_valid !== 1'b0) begin n_mis++; $display("FAIL post_flush_drain_valid got=%b exp=0", s_if.m_valid); end
      n_cmp++; if (rd_ptr !== 12'd11) begin n_mis++; $display("FAIL post_flush_rd_ptr got=%h exp=00b", rd_ptr); end
   endtask

   task automatic test_overflow();
      do_reset();
      wr_ptr = 12'h801;
      n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL ovf_pre_err got=%b exp=0", err); end
      step();
      n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL ovf_err got=%b exp=1", err); end
      n_cmp++; if (level !== 12'h801) begin n_mis++; $display("FAIL ovf_level got=%h exp=801", level); end
      wr_ptr = 12'd5;
      for (int k = 2; k <= 4; k++) begin
         step();
         n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL ovf_sticky cyc=%0d got=%b exp=1", k, err); end
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL ovf_flush_err got=%b exp=0", err); end
      n_cmp++; if (rd_ptr !== 12'd5) begin n_mis++; $display("FAIL ovf_flush_rd_ptr got=%h exp=005", rd_ptr); end
      step();
      n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL ovf_after_err got=%b exp=0", err); end
   endtask

   task automatic test_rst_mid();
      wr_ptr = 12'd9;
      s_if.m_ready = 1'b0;
      step();
      step();
      step();
      n_cmp++; if (s_if.m_valid !== 1'b1) begin n_mis++; $display("FAIL rstmid_pre_valid got=%b exp=1", s_if.m_valid); end
      rst = 1'b1;
      step();
      n_cmp++; if (s_if.m_valid !== 1'b0) begin n_mis++; $display("FAIL rstmid_valid got=%b exp=0", s_if.m_valid); end
      n_cmp++; if (rd_ptr !== 12'd0) begin n_mis++; $display("FAIL rstmid_rd_ptr got=%h exp=000", rd_ptr); end
      n_cmp++; if (ram_adr !== 11'd0) begin n_mis++; $display("FAIL rstmid_ram_adr got=%h exp=000", ram_adr); end
      wr_ptr = 12'd0;
      rst = 1'b0;
      step();
      n_cmp++; if (s_if.m_valid !== 1'b0) begin n_mis++; $display("FAIL rstmid_after_valid got=%b exp=0", s_if.m_valid); end
      n_cmp++; if (level !== 12'd0) begin n_mis++; $display("FAIL rstmid_after_level got=%h exp=000", level); end
   endtask

   initial begin
      s_if.m_ready = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_wrap();
      test_flush();
      test_overflow();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
